// File: rtl/ctrl_pkg.sv
// Shared encodings for the ID-stage instruction decoder: opcodes, function codes,
// ALU codes, writeback/PC selects and the decoded-control payload.
package ctrl_pkg;

    localparam int unsigned OP_W  = 6;
    localparam int unsigned FN_W  = 6;
    localparam int unsigned ALU_W = 4;
    localparam int unsigned SEL_W = 2;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'b001011;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [FN_W-1:0] FN_NOOP  = 6'b000000;
    localparam logic [FN_W-1:0] FN_XNOR  = 6'b001100;
    localparam logic [FN_W-1:0] FN_MFHI  = 6'b010000;
    localparam logic [FN_W-1:0] FN_MFLO  = 6'b010010;
    localparam logic [FN_W-1:0] FN_MULT  = 6'b011000;
    localparam logic [FN_W-1:0] FN_MULTU = 6'b011001;
    localparam logic [FN_W-1:0] FN_ADD   = 6'b100000;
    localparam logic [FN_W-1:0] FN_ADDU  = 6'b100001;
    localparam logic [FN_W-1:0] FN_SUB   = 6'b100010;
    localparam logic [FN_W-1:0] FN_SUBU  = 6'b100011;
    localparam logic [FN_W-1:0] FN_AND   = 6'b100100;
    localparam logic [FN_W-1:0] FN_OR    = 6'b100101;
    localparam logic [FN_W-1:0] FN_XOR   = 6'b100110;
    localparam logic [FN_W-1:0] FN_SLT   = 6'b101010;
    localparam logic [FN_W-1:0] FN_SLTU  = 6'b101011;

    localparam logic [ALU_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_XNOR = 4'b0011;
    localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'b1101;
    localparam logic [ALU_W-1:0] ALU_SLTU = 4'b1110;

    localparam logic [SEL_W-1:0] OUT_ALU = 2'b00;
    localparam logic [SEL_W-1:0] OUT_LUI = 2'b01;
    localparam logic [SEL_W-1:0] OUT_HI  = 2'b10;
    localparam logic [SEL_W-1:0] OUT_LO  = 2'b11;

    localparam logic [SEL_W-1:0] PC_SEQ = 2'b00;
    localparam logic [SEL_W-1:0] PC_BR  = 2'b01;
    localparam logic [SEL_W-1:0] PC_JMP = 2'b10;

    // Decoded controls other than ALU_Op, before reset gating.
    typedef struct packed {
        logic [SEL_W-1:0] pc_source;
        logic [SEL_W-1:0] out_select;
        logic             mem_write;
        logic             mem_read;
        logic             reg_write;
        logic             output_branch;
        logic             alu_src_a;
        logic             se_ze;
        logic             reg_dst;
        logic             start_mult;
        logic             mult_sign;
        logic             mem_to_reg;
    } ctrl_t;

    // R-type functions that produce a register result through the ALU.
    function automatic logic is_alu_fn(input logic [FN_W-1:0] func);
        case (func)
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
            FN_XOR, FN_XNOR, FN_SLT, FN_SLTU: is_alu_fn = 1'b1;
            default:                          is_alu_fn = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/controller_if.sv
// Decoder bundle: instruction fields and compare result in, datapath controls out.
interface controller_if;
    import ctrl_pkg::*;

    logic [OP_W-1:0]  OP;
    logic [FN_W-1:0]  Func;
    logic             Eq_ne;
    logic [SEL_W-1:0] PC_source;
    logic [SEL_W-1:0] Out_select;
    logic             MemWrite;
    logic             MemRead;
    logic             RegWrite;
    logic             Output_branch;
    logic             ALUSrcA;
    logic [ALU_W-1:0] ALU_Op;
    logic             Se_ze;
    logic             RegDst;
    logic             Start_mult;
    logic             Mult_sign;
    logic             MemtoReg;

    modport master (
        output OP, Func, Eq_ne,
        input  PC_source, Out_select, MemWrite, MemRead, RegWrite, Output_branch,
               ALUSrcA, ALU_Op, Se_ze, RegDst, Start_mult, Mult_sign, MemtoReg
    );

    modport slave (
        input  OP, Func, Eq_ne,
        output PC_source, Out_select, MemWrite, MemRead, RegWrite, Output_branch,
               ALUSrcA, ALU_Op, Se_ze, RegDst, Start_mult, Mult_sign, MemtoReg
    );
endinterface

// File: rtl/controller_alu_dec.sv
// ALU function-code decode from opcode and R-type function field.
module controller_alu_dec
    import ctrl_pkg::*;
(
    input  logic [OP_W-1:0]  op,
    input  logic [FN_W-1:0]  func,
    output logic [ALU_W-1:0] alu_op
);

    always_comb begin
        alu_op = ALU_AND;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_XOR:          alu_op = ALU_XOR;
                    FN_XNOR:         alu_op = ALU_XNOR;
                    FN_SLT:          alu_op = ALU_SLT;
                    FN_SLTU:         alu_op = ALU_SLTU;
                    default:         alu_op = ALU_AND;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: alu_op = ALU_ADD;
            OP_SLTI:                         alu_op = ALU_SLT;
            OP_SLTIU:                        alu_op = ALU_SLTU;
            OP_ANDI:                         alu_op = ALU_AND;
            OP_ORI:                          alu_op = ALU_OR;
            OP_XORI:                         alu_op = ALU_XOR;
            default:                         alu_op = ALU_AND;
        endcase
    end

endmodule

// File: rtl/controller.sv
// ID-stage main decoder: combinational decode of OP/Func/Eq_ne; a single armed flop
// holds state-changing controls low until the first clock after reset release.
module controller
    import ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    controller_if.slave  bus
);

    ctrl_t dec;
    logic  armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed <= 1'b0;
        else        armed <= 1'b1;
    end

    controller_alu_dec u_alu_dec (
        .op     (bus.OP),
        .func   (bus.Func),
        .alu_op (bus.ALU_Op)
    );

    // Main decode; anything not listed falls through as an all-zero NOP.
    always_comb begin
        dec = '0;
        case (bus.OP)
            OP_RTYPE: begin
                if (is_alu_fn(bus.Func)) begin
                    dec.reg_write = 1'b1;
                    dec.reg_dst   = 1'b1;
                end
                case (bus.Func)
                    FN_MFHI: begin
                        dec.reg_write  = 1'b1;
                        dec.reg_dst    = 1'b1;
                        dec.out_select = OUT_HI;
                    end
                    FN_MFLO: begin
                        dec.reg_write  = 1'b1;
                        dec.reg_dst    = 1'b1;
                        dec.out_select = OUT_LO;
                    end
                    FN_MULT: begin
                        dec.reg_dst    = 1'b1;
                        dec.start_mult = 1'b1;
                        dec.mult_sign  = 1'b1;
                    end
                    FN_MULTU: begin
                        dec.reg_dst    = 1'b1;
                        dec.start_mult = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                dec.reg_write = 1'b1;
                dec.alu_src_a = 1'b1;
                dec.se_ze     = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                dec.reg_write = 1'b1;
                dec.alu_src_a = 1'b1;
            end
            OP_LUI: begin
                dec.reg_write  = 1'b1;
                dec.alu_src_a  = 1'b1;
                dec.out_select = OUT_LUI;
            end
            OP_LW: begin
                dec.reg_write  = 1'b1;
                dec.alu_src_a  = 1'b1;
                dec.se_ze      = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                dec.alu_src_a = 1'b1;
                dec.se_ze     = 1'b1;
                dec.mem_write = 1'b1;
            end
            OP_J: begin
                dec.pc_source     = PC_JMP;
                dec.output_branch = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                // BEQ takes on equal, BNE on not-equal; opcode bit 0 selects the sense.
                if (bus.Eq_ne != bus.OP[0]) begin
                    dec.pc_source     = PC_BR;
                    dec.output_branch = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.PC_source     = armed ? dec.pc_source : PC_SEQ;
    assign bus.Out_select    = dec.out_select;
    assign bus.MemWrite      = dec.mem_write     & armed;
    assign bus.MemRead       = dec.mem_read      & armed;
    assign bus.RegWrite      = dec.reg_write     & armed;
    assign bus.Output_branch = dec.output_branch & armed;
    assign bus.ALUSrcA       = dec.alu_src_a;
    assign bus.Se_ze         = dec.se_ze;
    assign bus.RegDst        = dec.reg_dst;
    assign bus.Start_mult    = dec.start_mult    & armed;
    assign bus.Mult_sign     = dec.mult_sign;
    assign bus.MemtoReg      = dec.mem_to_reg;

endmodule

// File: tb/tb_controller.sv
// Directed bench for the ID-stage decoder: reset gating, R/I/branch/jump decode, illegal codes.
module tb_controller;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    controller_if bus ();

    controller u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PC_source, Out_select, MemWrite, MemRead, RegWrite, Output_branch, ALUSrcA,
    //  ALU_Op, Se_ze, RegDst, Start_mult, Mult_sign, MemtoReg}
    function automatic logic [17:0] obs_v();
        return {bus.PC_source, bus.Out_select, bus.MemWrite, bus.MemRead, bus.RegWrite,
                bus.Output_branch, bus.ALUSrcA, bus.ALU_Op, bus.Se_ze, bus.RegDst,
                bus.Start_mult, bus.Mult_sign, bus.MemtoReg};
    endfunction

    function automatic logic [17:0] ev(input logic [1:0] pc, input logic [1:0] os,
                                       input logic mw, input logic mr, input logic rw,
                                       input logic ob, input logic as, input logic [3:0] alu,
                                       input logic se, input logic rd, input logic sm,
                                       input logic ms, input logic m2r);
        return {pc, os, mw, mr, rw, ob, as, alu, se, rd, sm, ms, m2r};
    endfunction

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic eq);
        @(negedge clk);
        bus.OP    = op;
        bus.Func  = fn;
        bus.Eq_ne = eq;
        #1;
    endtask

    task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic eq, input logic [17:0] exp);
        drive(op, fn, eq);
        chk(tag, obs_v(), exp);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.OP    = 6'b100011;
        bus.Func  = 6'b000000;
        bus.Eq_ne = 1'b0;

        // Held in reset: side effects gated, other fields still decode
        drive(6'b100011, 6'b000000, 1'b0);
        chk("rst_lw_memread",  18'(bus.MemRead),  18'(1'b0));
        chk("rst_lw_regwrite", 18'(bus.RegWrite), 18'(1'b0));
        chk("rst_lw_vec", obs_v(), ev(2'b00, 2'b00, 0, 0, 0, 0, 1, 4'b0100, 1, 0, 0, 0, 1));
        step("rst_beq_taken", 6'b000100, 6'b000000, 1'b1, 18'h0);
        step("rst_j",         6'b000010, 6'b000000, 1'b0, 18'h0);
        drive(6'b000000, 6'b011000, 1'b0);
        chk("rst_mult_start", 18'(bus.Start_mult), 18'(1'b0));
        chk("rst_mult_sign",  18'(bus.Mult_sign),  18'(1'b1));

        // Released but no clock edge yet: still gated
        drive(6'b100011, 6'b000000, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("prearm_lw_memread", 18'(bus.MemRead), 18'(1'b0));
        @(posedge clk);
        #1;
        chk("arm_lw_vec", obs_v(), ev(2'b00, 2'b00, 0, 1, 1, 0, 1, 4'b0100, 1, 0, 0, 0, 1));

        // R-type ALU sweep
        step("r_add",  6'b000000, 6'b100000, 1'b0, ev(0, 0, 0, 0, 1, 0, 0, 4'b0100, 0, 1, 0, 0, 0));
        step("r_addu", 6'b000000, 6'b100001, 1'b1, ev(0, 0, 0, 0, 1, 0, 0, 4'b0100, 0, 1, 0, 0, 0));
        step("r_sub",  6'b000000, 6'b100010, 1'b0, ev(0, 0, 0, 0, 1, 0, 0, 4'b1000, 0, 1, 0, 0, 0));
        step("r_subu", 6'b000000, 6'b100011, 1'b0, ev(0, 0, 0, 0, 1, 0, 0, 4'b1000, 0, 1, 0, 0, 0));
        step("r_and",  6'b000000, 6'b100100, 1'b0, ev(0, 0, 0, 0, 1, 0, 0, 4'b0000, 0, 1, 0, 0, 0));
        step("r_or",   6'b000000, 6'b100101, 1'b0, ev(0, 0, 0, 0, 1, 0, 0, 4'b0001, 0, 1, 0, 0, 0));
        step("r_xor",  6'b000000, 6'b100110, 1'b0, ev(0, 0, 0, 0, 1, 0, 0, 4'b0010, 0, 1, 0, 0, 0));
        step("r_xnor", 6'b000000, 6'b001100, 1'b0, ev(0, 0, 0, 0, 1, 0, 0, 4'b0011, 0, 1, 0, 0, 0));
        step("r_slt",  6'b000000, 6'b101010, 1'b0, ev(0, 0, 0, 0, 1, 0, 0, 4'b1101, 0, 1, 0, 0, 0));
        step("r_sltu", 6'b000000, 6'b101011, 1'b0, ev(0, 0, 0, 0, 1, 0, 0, 4'b1110, 0, 1, 0, 0, 0));
        step("r_mfhi", 6'b000000, 6'b010000, 1'b0, ev(0, 2, 0, 0, 1, 0, 0, 4'b0000, 0, 1, 0, 0, 0));
        step("r_mflo", 6'b000000, 6'b010010, 1'b0, ev(0, 3, 0, 0, 1, 0, 0, 4'b0000, 0, 1, 0, 0, 0));
        step("r_noop", 6'b000000, 6'b000000, 1'b1, 18'h0);

        drive(6'b000000, 6'b011000, 1'b0);
        chk("mult_start", 18'(bus.Start_mult), 18'(1'b1));
        chk("mult_sign",  18'(bus.Mult_sign),  18'(1'b1));
        chk("mult_rw",    18'(bus.RegWrite),   18'(1'b0));
        chk("mult_mw",    18'(bus.MemWrite),   18'(1'b0));
        drive(6'b000000, 6'b011001, 1'b0);
        chk("multu_start", 18'(bus.Start_mult), 18'(1'b1));
        chk("multu_sign",  18'(bus.Mult_sign),  18'(1'b0));
        chk("multu_rw",    18'(bus.RegWrite),   18'(1'b0));

        // Branches and jump
        step("beq_taken", 6'b000100, 6'b000000, 1'b1, ev(1, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 0, 0, 0, 0));
        drive(6'b000100, 6'b000000, 1'b1);
        bus.Eq_ne = 1'b0;
        #1;
        chk("beq_flip_nt", obs_v(), 18'h0);
        step("bne_taken", 6'b000101, 6'b000000, 1'b0, ev(1, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 0, 0, 0, 0));
        step("bne_nt",    6'b000101, 6'b000000, 1'b1, 18'h0);
        step("jump",      6'b000010, 6'b100000, 1'b1, ev(2, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 0, 0, 0, 0));

        // Immediates and memory
        step("addi",  6'b001000, 6'b000000, 1'b1, ev(0, 0, 0, 0, 1, 0, 1, 4'b0100, 1, 0, 0, 0, 0));
        step("addiu", 6'b001001, 6'b000000, 1'b0, ev(0, 0, 0, 0, 1, 0, 1, 4'b0100, 1, 0, 0, 0, 0));
        step("slti",  6'b001010, 6'b000000, 1'b0, ev(0, 0, 0, 0, 1, 0, 1, 4'b1101, 1, 0, 0, 0, 0));
        step("sltiu", 6'b001011, 6'b000000, 1'b0, ev(0, 0, 0, 0, 1, 0, 1, 4'b1110, 1, 0, 0, 0, 0));
        step("andi",  6'b001100, 6'b000000, 1'b0, ev(0, 0, 0, 0, 1, 0, 1, 4'b0000, 0, 0, 0, 0, 0));
        step("ori",   6'b001101, 6'b000000, 1'b0, ev(0, 0, 0, 0, 1, 0, 1, 4'b0001, 0, 0, 0, 0, 0));
        step("xori",  6'b001110, 6'b000000, 1'b0, ev(0, 0, 0, 0, 1, 0, 1, 4'b0010, 0, 0, 0, 0, 0));
        step("lui",   6'b001111, 6'b000000, 1'b0, ev(0, 1, 0, 0, 1, 0, 1, 4'b0000, 0, 0, 0, 0, 0));
        step("sw",    6'b101011, 6'b000000, 1'b0, ev(0, 0, 1, 0, 0, 0, 1, 4'b0100, 1, 0, 0, 0, 0));

        // Illegal encodings
        step("ill_op", 6'b111111, 6'b100000, 1'b1, 18'h0);
        step("ill_fn", 6'b000000, 6'b111111, 1'b1, 18'h0);

        // Asynchronous re-assertion gates side effects immediately
        drive(6'b101011, 6'b000000, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rerst_sw_vec", obs_v(), ev(0, 0, 0, 0, 0, 0, 1, 4'b0100, 1, 0, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
